mem_wb_skid_stage: RTL and testbench
====================================

Name: mem_wb_skid_stage

Overview:
- Next-generation MEM->WB pipeline stage register, parametrised in data width and register-file address width.
- Adds ready/valid handshake, a 2-entry skid buffer, flush (bubble insertion), write-enable gating on bubbles, occupancy output and a saturating backpressure counter.
- Sits between the memory-access stage and the writeback mux/register file.
- Lets WB stall without a combinational ready path back into MEM.

Parameters:
- XLEN, 16, datapath width of pc_plus2, alu_res and read_data.
- REG_AW, 4, register-file address width (rd).
- RSRC_W, 2, width of the result-source select.
- CNT_W, 16, width of the stall_cycles counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  MEM presents a valid payload.
- in_ready  out  1  stage can accept this cycle.
- in_reg_write  in  1  register-file write enable.
- in_result_src  in  RSRC_W  writeback source select.
- in_pc_plus2  in  XLEN  PC+2 of the instruction.
- in_rd  in  REG_AW  destination register.
- in_alu_res  in  XLEN  ALU result.
- in_read_data  in  XLEN  data-memory read value.
- out_valid  out  1  payload presented to WB.
- out_ready  in  1  WB consumes this cycle.
- out_reg_write, out_result_src, out_pc_plus2, out_rd, out_alu_res, out_read_data  out  (as input widths)  head-entry payload.
- occupancy  out  2  number of held entries, 0..2.
- stall_cycles  out  CNT_W  saturating count of backpressure cycles.

Behaviour:
- Storage: entry A (head, drives out_*) and entry B (skid). Each entry has a valid bit and a full payload. out_valid = A.valid.
- in_ready = ~B.valid. It is a pure register output with no combinational path from out_ready.
- accept = in_valid & in_ready & ~flush.
- drain = A.valid & out_ready.
- Next-state, evaluated in priority order:
  1. flush: A.valid = 0, B.valid = 0. Input is dropped. An entry draining in the same cycle counts as consumed by WB.
  2. A empty: if accept, payload goes to A.
  3. A full, B empty:
     - drain & accept: payload goes to A.
     - drain only: A empties.
     - no drain & accept: payload goes to B.
     - no drain, no accept: hold.
  4. A full, B full: drain moves B to A and B empties; no drain holds. No accept is possible because in_ready = 0.
- Ordering is strict FIFO. No payload is duplicated or lost except by flush.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Throughput is 1 per cycle while out_ready = 1.
- out_reg_write = A.valid & A.reg_write. A bubble never writes the register file.
- Other out_* fields show the A payload regardless of valid. They hold their last value while invalid, so payload registers update only on load.
- occupancy = A.valid + B.valid.
- stall_cycles increments when out_valid & ~out_ready. It saturates at 2^CNT_W - 1 and clears only on reset.
- Reset, asynchronous: both valid bits, all payload registers and stall_cycles go to 0. Consequences:
  - out_valid = 0, out_reg_write = 0, occupancy = 0, all out_* = 0.
  - in_ready = 1 after deassert.
- Reset asserted mid-transfer discards everything. No partial state survives.

Decomposition:
- Package mem_wb_pkg:
  - typedef wb_payload_t: packed struct {reg_write, result_src, pc_plus2, rd, alu_res, read_data}, sized from the package parameters.
  - Result-source encodings RES_ALU = 2'd0, RES_MEM = 2'd1, RES_PC2 = 2'd2.
- The skid-buffer control and storage form one sub-module, skid_buffer2, parametrised on payload width. mem_wb_skid_stage adds the write-enable gating, occupancy and the counter around it.

Test Plan:
- Reset: after reset release, out_valid = 0, out_reg_write = 0, occupancy = 0, in_ready = 1, stall_cycles = 0.
- Streaming: push rd = 1..5 with alu_res = 16'h0011..16'h0055, out_ready = 1 -> same sequence appears 1 cycle later, back-to-back, occupancy stays 1.
- Backpressure: push rd = 3, rd = 4, out_ready = 0 -> occupancy = 2, in_ready = 0 next cycle, stall_cycles counts up. Raising out_ready then yields rd = 3 then rd = 4, and in_ready returns to 1.
- Flush: occupancy = 2 with in_valid = 1 and flush = 1 -> next cycle occupancy = 0, out_valid = 0, out_reg_write = 0, and the input is not captured.
- Bubble gating: push in_valid = 1 with in_reg_write = 1, then hold in_valid = 0 -> out_reg_write = 1 for one cycle only, while out_rd holds its last value.
- Saturation: with CNT_W = 4, hold out_valid = 1 and out_ready = 0 for 20 cycles -> stall_cycles = 15 and stays there. Reset mid-stall -> 0.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// MEM->WB stage shared types: writeback payload bundle
// and result-source select encodings.
package mem_wb_pkg;

  localparam int PKG_XLEN   = 16;
  localparam int PKG_REG_AW = 4;
  localparam int PKG_RSRC_W = 2;
  localparam int PKG_CNT_W  = 16;

  localparam logic [PKG_RSRC_W-1:0] RES_ALU = 2'd0;
  localparam logic [PKG_RSRC_W-1:0] RES_MEM = 2'd1;
  localparam logic [PKG_RSRC_W-1:0] RES_PC2 = 2'd2;

  typedef struct packed {
    logic                  reg_write;
    logic [PKG_RSRC_W-1:0] result_src;
    logic [PKG_XLEN-1:0]   pc_plus2;
    logic [PKG_REG_AW-1:0] rd;
    logic [PKG_XLEN-1:0]   alu_res;
    logic [PKG_XLEN-1:0]   read_data;
  } wb_payload_t;

  localparam int WB_PAYLOAD_W = $bits(wb_payload_t);

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry skid buffer: head entry A drives the output, B absorbs
// the one extra beat accepted while the consumer stalls.
module skid_buffer2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         a_valid,
  output logic         b_valid
);

  logic         r_a_valid;
  logic         r_b_valid;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic         w_accept;
  logic         w_drain;

  assign in_ready  = ~r_b_valid;
  assign out_valid = r_a_valid;
  assign out_data  = r_a;
  assign a_valid   = r_a_valid;
  assign b_valid   = r_b_valid;

  assign w_accept = in_valid & ~r_b_valid & ~flush;
  assign w_drain  = r_a_valid & out_ready;

  // Payload registers load only on capture, so out_data holds when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_valid <= 1'b0;
      r_b_valid <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
    end else if (flush) begin
      r_a_valid <= 1'b0;
      r_b_valid <= 1'b0;
    end else if (!r_a_valid) begin
      if (w_accept) begin
        r_a       <= in_data;
        r_a_valid <= 1'b1;
      end
    end else if (!r_b_valid) begin
      if (w_drain && w_accept) begin
        r_a <= in_data;
      end else if (w_drain) begin
        r_a_valid <= 1'b0;
      end else if (w_accept) begin
        r_b       <= in_data;
        r_b_valid <= 1'b1;
      end
    end else if (w_drain) begin
      r_a       <= r_b;
      r_b_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline register with ready/valid skid buffering,
// bubble write-enable gating, occupancy and stall counter.
module mem_wb_skid_stage
  import mem_wb_pkg::*;
#(
  parameter int XLEN   = PKG_XLEN,
  parameter int REG_AW = PKG_REG_AW,
  parameter int RSRC_W = PKG_RSRC_W,
  parameter int CNT_W  = PKG_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [RSRC_W-1:0] in_result_src,
  input  logic [XLEN-1:0]   in_pc_plus2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_alu_res,
  input  logic [XLEN-1:0]   in_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_reg_write,
  output logic [RSRC_W-1:0] out_result_src,
  output logic [XLEN-1:0]   out_pc_plus2,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_alu_res,
  output logic [XLEN-1:0]   out_read_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int PW = 1 + RSRC_W + REG_AW + 3 * XLEN;

  logic [PW-1:0]    w_in;
  logic [PW-1:0]    w_head;
  logic             w_head_rw;
  logic             w_a_valid;
  logic             w_b_valid;
  logic [CNT_W-1:0] r_stall;

  assign w_in = {in_reg_write, in_result_src, in_pc_plus2,
                 in_rd, in_alu_res, in_read_data};

  assign {w_head_rw, out_result_src, out_pc_plus2,
          out_rd, out_alu_res, out_read_data} = w_head;

  skid_buffer2 #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_head),
    .a_valid   (w_a_valid),
    .b_valid   (w_b_valid)
  );

  // A bubble in the head slot must never write the register file.
  assign out_reg_write = w_a_valid & w_head_rw;

  assign occupancy = {w_a_valid & w_b_valid, w_a_valid ^ w_b_valid};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall <= '0;
    end else if (out_valid && !out_ready && !(&r_stall)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Randomised and directed bench for mem_wb_skid_stage against
// a queue-based FIFO reference model.
module tb_mem_wb_skid_stage;
  import mem_wb_pkg::*;

  localparam int XLEN   = PKG_XLEN;
  localparam int REG_AW = PKG_REG_AW;
  localparam int RSRC_W = PKG_RSRC_W;
  localparam int CNT_W  = 4;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_reg_write = 1'b0;
  logic [RSRC_W-1:0] in_result_src = '0;
  logic [XLEN-1:0]   in_pc_plus2 = '0;
  logic [REG_AW-1:0] in_rd = '0;
  logic [XLEN-1:0]   in_alu_res = '0;
  logic [XLEN-1:0]   in_read_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_reg_write;
  logic [RSRC_W-1:0] out_result_src;
  logic [XLEN-1:0]   out_pc_plus2;
  logic [REG_AW-1:0] out_rd;
  logic [XLEN-1:0]   out_alu_res;
  logic [XLEN-1:0]   out_read_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  wb_payload_t q[$];
  wb_payload_t m_head;
  int          m_stall;

  mem_wb_skid_stage #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW),
    .RSRC_W (RSRC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_reg_write   (in_reg_write),
    .in_result_src  (in_result_src),
    .in_pc_plus2    (in_pc_plus2),
    .in_rd          (in_rd),
    .in_alu_res     (in_alu_res),
    .in_read_data   (in_read_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_reg_write  (out_reg_write),
    .out_result_src (out_result_src),
    .out_pc_plus2   (out_pc_plus2),
    .out_rd         (out_rd),
    .out_alu_res    (out_alu_res),
    .out_read_data  (out_read_data),
    .occupancy      (occupancy),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic wb_payload_t cur_in();
    wb_payload_t p;
    p.reg_write  = in_reg_write;
    p.result_src = in_result_src;
    p.pc_plus2   = in_pc_plus2;
    p.rd         = in_rd;
    p.alu_res    = in_alu_res;
    p.read_data  = in_read_data;
    return p;
  endfunction

  task automatic drive(input logic v, input logic [REG_AW-1:0] rd,
                       input logic [XLEN-1:0] alu, input logic rw);
    in_valid      = v;
    in_rd         = rd;
    in_alu_res    = alu;
    in_reg_write  = rw;
    in_result_src = RES_ALU;
    in_pc_plus2   = XLEN'($urandom);
    in_read_data  = XLEN'($urandom);
  endtask

  task automatic drive_rand();
    in_valid      = 1'($urandom);
    in_reg_write  = 1'($urandom);
    in_result_src = RSRC_W'($urandom_range(0, 2));
    in_pc_plus2   = XLEN'($urandom);
    in_rd         = REG_AW'($urandom);
    in_alu_res    = XLEN'($urandom);
    in_read_data  = XLEN'($urandom);
  endtask

  task automatic model_reset();
    q.delete();
    m_head  = '0;
    m_stall = 0;
  endtask

  // Model: FIFO of depth 2 observed at each rising edge.
  task automatic tick();
    bit drain;
    bit acc;
    @(posedge clk);
    drain = (q.size() > 0) && out_ready;
    acc   = in_valid && (q.size() < 2) && !flush;
    if (q.size() > 0 && !out_ready && m_stall < SAT) m_stall++;
    if (flush) begin
      q.delete();
    end else begin
      if (drain) void'(q.pop_front());
      if (acc) q.push_back(cur_in());
    end
    if (q.size() > 0) m_head = q[0];
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    n_checks += 5;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    if (out_reg_write !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_reg_write got=%b exp=0", out_reg_write);
    end
    if (occupancy !== 2'd0) begin
      n_fail++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy);
    end
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    if (stall_cycles !== '0) begin
      n_fail++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles);
    end
  endtask

  task automatic test_streaming();
    logic [XLEN-1:0] alu;
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      alu = XLEN'(16'h0011 * i);
      drive(1'b1, REG_AW'(i), alu, 1'b1);
      tick();
      n_checks += 4;
      if (out_valid !== 1'b1) begin
        n_fail++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid);
      end
      if (out_rd !== REG_AW'(i)) begin
        n_fail++; $display("FAIL stream_rd[%0d] got=%0d exp=%0d", i, out_rd, i);
      end
      if (out_alu_res !== alu) begin
        n_fail++; $display("FAIL stream_alu[%0d] got=%h exp=%h", i, out_alu_res, alu);
      end
      if (occupancy !== 2'd1) begin
        n_fail++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, occupancy);
      end
    end
    drive(1'b0, '0, '0, 1'b0);
    tick();
    n_checks += 1;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain got occ=%0d v=%b exp occ=0 v=0", occupancy, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 4'd3, 16'h0033, 1'b1);
    tick();
    drive(1'b1, 4'd4, 16'h0044, 1'b1);
    tick();
    n_checks += 2;
    if (occupancy !== 2'd2) begin
      n_fail++; $display("FAIL bp_occ got=%0d exp=2", occupancy);
    end
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_in_ready got=%b exp=0", in_ready);
    end
    drive(1'b1, 4'd9, 16'h0099, 1'b1);
    tick();
    tick();
    n_checks += 3;
    if (stall_cycles !== CNT_W'(3)) begin
      n_fail++; $display("FAIL bp_stall got=%0d exp=3", stall_cycles);
    end
    if (out_rd !== 4'd3) begin
      n_fail++; $display("FAIL bp_head got=%0d exp=3", out_rd);
    end
    if (occupancy !== 2'd2) begin
      n_fail++; $display("FAIL bp_hold_occ got=%0d exp=2", occupancy);
    end
    drive(1'b0, '0, '0, 1'b0);
    out_ready = 1'b1;
    tick();
    n_checks += 2;
    if (out_rd !== 4'd4 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_second got rd=%0d v=%b exp rd=4 v=1", out_rd, out_valid);
    end
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready_back got=%b exp=1", in_ready);
    end
    tick();
    n_checks += 1;
    if (occupancy !== 2'd0) begin
      n_fail++; $display("FAIL bp_empty got=%0d exp=0", occupancy);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 4'd5, 16'h0055, 1'b1);
    tick();
    drive(1'b1, 4'd6, 16'h0066, 1'b1);
    tick();
    drive(1'b1, 4'd7, 16'h0077, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks += 3;
    if (occupancy !== 2'd0) begin
      n_fail++; $display("FAIL flush_occ got=%0d exp=0", occupancy);
    end
    if (out_valid !== 1'b0 || out_reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_valid got v=%b rw=%b exp 0 0", out_valid, out_reg_write);
    end
    if (stall_cycles !== CNT_W'(m_stall)) begin
      n_fail++; $display("FAIL flush_stall got=%0d exp=%0d", stall_cycles, m_stall);
    end
    drive(1'b0, '0, '0, 1'b0);
    tick();
    n_checks += 1;
    if (occupancy !== 2'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_drop got occ=%0d rdy=%b exp 0 1", occupancy, in_ready);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    drive(1'b1, 4'd10, 16'h00aa, 1'b1);
    tick();
    n_checks += 1;
    if (out_reg_write !== 1'b1 || out_rd !== 4'd10) begin
      n_fail++;
      $display("FAIL bubble_first got rw=%b rd=%0d exp 1 10", out_reg_write, out_rd);
    end
    drive(1'b0, 4'd2, 16'h0022, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks += 2;
      if (out_reg_write !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL bubble_gate[%0d] got rw=%b v=%b exp 0 0", i, out_reg_write, out_valid);
      end
      if (out_rd !== 4'd10 || out_alu_res !== 16'h00aa) begin
        n_fail++;
        $display("FAIL bubble_hold[%0d] got rd=%0d alu=%h exp 10 00aa", i, out_rd, out_alu_res);
      end
    end
  endtask

  task automatic test_saturation();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    out_ready = 1'b0;
    drive(1'b1, 4'd1, 16'h0001, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    repeat (20) tick();
    n_checks += 1;
    if (stall_cycles !== CNT_W'(SAT)) begin
      n_fail++; $display("FAIL sat_value got=%0d exp=%0d", stall_cycles, SAT);
    end
    repeat (3) tick();
    n_checks += 1;
    if (stall_cycles !== CNT_W'(SAT)) begin
      n_fail++; $display("FAIL sat_hold got=%0d exp=%0d", stall_cycles, SAT);
    end
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_checks += 2;
    if (stall_cycles !== '0) begin
      n_fail++; $display("FAIL sat_reset got=%0d exp=0", stall_cycles);
    end
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_occ got occ=%0d v=%b exp 0 0", occupancy, out_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    bit          ev;
    wb_payload_t got;
    for (int c = 0; c < 400; c++) begin
      drive_rand();
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 4);
      tick();
      ev  = (q.size() > 0);
      got = '{out_reg_write, out_result_src, out_pc_plus2,
              out_rd, out_alu_res, out_read_data};
      got.reg_write = m_head.reg_write;
      n_checks += 6;
      if (out_valid !== ev) begin
        n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, ev);
      end
      if (in_ready !== (q.size() < 2)) begin
        n_fail++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, q.size() < 2);
      end
      if (occupancy !== 2'(q.size())) begin
        n_fail++; $display("FAIL rnd_occ c=%0d got=%0d exp=%0d", c, occupancy, q.size());
      end
      if (out_reg_write !== (ev & m_head.reg_write)) begin
        n_fail++;
        $display("FAIL rnd_reg_write c=%0d got=%b exp=%b", c, out_reg_write, ev & m_head.reg_write);
      end
      if (got !== m_head) begin
        n_fail++; $display("FAIL rnd_payload c=%0d got=%h exp=%h", c, got, m_head);
      end
      if (stall_cycles !== CNT_W'(m_stall)) begin
        n_fail++; $display("FAIL rnd_stall c=%0d got=%0d exp=%0d", c, stall_cycles, m_stall);
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
